axi4_lite_read_slave: RTL and testbench



---
 rtl/axi4_lite_pkg.sv | 15 +
 rtl/sram_1r1w.sv | 25 ++
 rtl/axi4_lite_read_slave.sv | 114 +++++++++++
 tb/tb_axi4_lite_read_slave.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes and slave FSM states.
// Used by the read slave, the read master and the future write slave.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/sram_1r1w.sv
// Word memory: asynchronous read port, synchronous write port.
// Contents are not reset; the loader preloads them.
module sram_1r1w #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[raddr];

  // write lands on the edge; a same-edge read still sees old data
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/axi4_lite_read_slave.sv
// AXI4-Lite read-only slave over sram_1r1w with a fixed,
// programmable response latency and a backdoor preload port.
module axi4_lite_read_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] AR_ADDR,
  input  logic              AR_VALID,
  input  logic [2:0]        AR_PROT,
  output logic              AR_READY,
  output logic [DATA_W-1:0] R_DATA,
  output logic [1:0]        R_RESP,
  output logic              R_VALID,
  input  logic              R_READY,
  input  logic              MEM_WE,
  input  logic [ADDR_W-1:0] MEM_WADDR,
  input  logic [DATA_W-1:0] MEM_WDATA
);

  localparam int OFF = $clog2(DATA_W / 8);
  localparam int AW  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              load;
  logic              idle_rdy;

  logic [ADDR_W-1:0] ar_idx, w_idx;
  logic              ar_ok, w_ok;
  logic [DATA_W-1:0] mem_rdata;

  logic              unused_prot;
  assign unused_prot = ^AR_PROT;

  assign ar_idx = AR_ADDR >> OFF;
  assign w_idx  = MEM_WADDR >> OFF;
  assign ar_ok  = ar_idx < DEPTH_W;
  assign w_ok   = w_idx < DEPTH_W;

  sram_1r1w #(
    .DATA_W(DATA_W),
    .DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk  (clk),
    .raddr(ar_idx[AW-1:0]),
    .rdata(mem_rdata),
    .we   (MEM_WE & w_ok),
    .waddr(w_idx[AW-1:0]),
    .wdata(MEM_WDATA)
  );

  assign AR_READY = idle_rdy & ~rst;
  assign R_DATA   = rdata_q;
  assign R_RESP   = rresp_q;

  // next state, latency counter and handshake outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    idle_rdy = 1'b0;
    R_VALID  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        idle_rdy = 1'b1;
        if (AR_VALID) begin
          load = 1'b1;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        R_VALID = 1'b1;
        if (R_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, counter and response captured at the AR handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        rdata_q <= ar_ok ? mem_rdata : '0;
        rresp_q <= ar_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_read_slave.sv
// Directed bench for axi4_lite_read_slave at LATENCY 2, 1 and 15.
// Instance 0: LATENCY 2, instance 1: LATENCY 1, instance 2: LATENCY 15.
module tb_axi4_lite_read_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ar_addr;
  logic [2:0]  ar_valid;
  logic [2:0]  ar_prot;
  logic [2:0]  ar_ready;
  logic [63:0] r_data [3];
  logic [1:0]  r_resp [3];
  logic [2:0]  r_valid;
  logic        r_ready;
  logic        mem_we;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 2 : (k == 1) ? 1 : 15;
    axi4_lite_read_slave #(
      .ADDR_W   (64),
      .DATA_W   (64),
      .MEM_DEPTH(1024),
      .LATENCY  (L)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .AR_ADDR  (ar_addr),
      .AR_VALID (ar_valid[k]),
      .AR_PROT  (ar_prot),
      .AR_READY (ar_ready[k]),
      .R_DATA   (r_data[k]),
      .R_RESP   (r_resp[k]),
      .R_VALID  (r_valid[k]),
      .R_READY  (r_ready),
      .MEM_WE   (mem_we),
      .MEM_WADDR(mem_waddr),
      .MEM_WDATA(mem_wdata)
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [63:0] a, input logic [63:0] d);
    mem_waddr = a;
    mem_wdata = d;
    mem_we    = 1'b1;
    step();
    mem_we    = 1'b0;
  endtask

  // issue AR on instance k; return cycles until R_VALID (99 on timeout)
  task automatic do_read(input int k, input logic [63:0] a,
                         output int lat);
    ar_addr     = a;
    ar_valid[k] = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
      if (lat == 1) begin
        ar_valid[k] = 1'b0;
        mem_we      = 1'b0;
      end
    end while (!r_valid[k] && lat < 40);
    if (!r_valid[k]) lat = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if (ar_ready !== 3'b000) begin
      bad++;
      $display("FAIL rst_arready got=%b want=000", ar_ready);
    end
    step();
    rst = 1'b0;
    step();
    total++;
    if (ar_ready !== 3'b111 || r_valid !== 3'b000) begin
      bad++;
      $display("FAIL rst_release arready=%b rvalid=%b want 111/000",
               ar_ready, r_valid);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (r_data[k] !== 64'h0 || r_resp[k] !== 2'b00) begin
        bad++;
        $display("FAIL rst_r%0d data=%h resp=%b want 0/00",
                 k, r_data[k], r_resp[k]);
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    bd_write(64'h80, 64'h1122334455667788);
    r_ready = 1'b1;
    do_read(0, 64'h80, lat);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL basic_lat got=%0d want=2", lat);
    end
    total++;
    if (r_data[0] !== 64'h1122334455667788 || r_resp[0] !== 2'b00) begin
      bad++;
      $display("FAIL basic_data got=%h/%b want=1122334455667788/00",
               r_data[0], r_resp[0]);
    end
    total++;
    if (ar_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy arready got=%b want=0", ar_ready[0]);
    end
    step();
    total++;
    if (r_valid[0] !== 1'b0 || ar_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL basic_done rvalid=%b arready=%b want 0/1",
               r_valid[0], ar_ready[0]);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int extra;
    r_ready = 1'b0;
    ar_prot = 3'b111;
    do_read(0, 64'h85, lat);
    total++;
    if (lat !== 2 || r_data[0] !== 64'h1122334455667788) begin
      bad++;
      $display("FAIL bp_first lat=%0d data=%h want 2/1122334455667788",
               lat, r_data[0]);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) bd_write(64'h80, 64'hFFFF);
      else step();
      total++;
      if (r_valid[0] !== 1'b1 || r_resp[0] !== 2'b00 ||
          r_data[0] !== 64'h1122334455667788) begin
        bad++;
        $display("FAIL bp_hold%0d v=%b d=%h r=%b want 1/1122334455667788/00",
                 c, r_valid[0], r_data[0], r_resp[0]);
      end
    end
    r_ready = 1'b1;
    step();
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      if (r_valid[0]) extra++;
      step();
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL bp_single extra_valid_cycles=%0d want=0", extra);
    end
    ar_prot = 3'b000;
    bd_write(64'h80, 64'h1122334455667788);
  endtask

  task automatic test_out_of_range();
    int lat;
    r_ready = 1'b1;
    bd_write(64'h0, 64'h0123);
    bd_write(64'h2000, 64'hDEAD);
    do_read(0, 64'h2000, lat);
    total++;
    if (lat !== 2 || r_resp[0] !== 2'b10 || r_data[0] !== 64'h0) begin
      bad++;
      $display("FAIL oor lat=%0d resp=%b data=%h want 2/10/0",
               lat, r_resp[0], r_data[0]);
    end
    step();
    do_read(0, 64'h0, lat);
    total++;
    if (r_resp[0] !== 2'b00 || r_data[0] !== 64'h0123) begin
      bad++;
      $display("FAIL oor_drop resp=%b data=%h want 00/0123",
               r_resp[0], r_data[0]);
    end
    step();
  endtask

  task automatic test_collision();
    int lat;
    r_ready = 1'b1;
    bd_write(64'h10, 64'h5555);
    mem_waddr = 64'h10;
    mem_wdata = 64'hAAAA;
    mem_we    = 1'b1;
    do_read(0, 64'h10, lat);
    total++;
    if (r_data[0] !== 64'h5555) begin
      bad++;
      $display("FAIL coll_old got=%h want=5555", r_data[0]);
    end
    step();
    do_read(0, 64'h10, lat);
    total++;
    if (r_data[0] !== 64'hAAAA) begin
      bad++;
      $display("FAIL coll_new got=%h want=aaaa", r_data[0]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    int extra;
    r_ready = 1'b1;
    ar_addr = 64'h80;
    ar_valid[2] = 1'b1;
    step();
    ar_valid[2] = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    total++;
    if (r_valid !== 3'b000) begin
      bad++;
      $display("FAIL rst_wait rvalid=%b want=000", r_valid);
    end
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (r_valid[2]) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL rst_wait_ghost cycles=%0d want=0", extra);
    end
    r_ready = 1'b0;
    do_read(0, 64'h80, lat);
    rst = 1'b1;
    step();
    total++;
    if (r_valid[0] !== 1'b0 || ar_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_resp rvalid=%b arready=%b want 0/0",
               r_valid[0], ar_ready[0]);
    end
    rst = 1'b0;
    r_ready = 1'b1;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (r_valid[0]) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL rst_resp_ghost cycles=%0d want=0", extra);
    end
    do_read(0, 64'h80, lat);
    total++;
    if (lat !== 2 || r_data[0] !== 64'h1122334455667788) begin
      bad++;
      $display("FAIL rst_recover lat=%0d data=%h want 2/1122334455667788",
               lat, r_data[0]);
    end
    step();
  endtask

  task automatic test_lat1_back_to_back();
    int lat;
    r_ready = 1'b1;
    do_read(1, 64'h80, lat);
    total++;
    if (lat !== 1 || r_data[1] !== 64'h1122334455667788) begin
      bad++;
      $display("FAIL lat1 lat=%0d data=%h want 1/1122334455667788",
               lat, r_data[1]);
    end
    step();
    total++;
    if (ar_ready[1] !== 1'b1 || r_valid[1] !== 1'b0) begin
      bad++;
      $display("FAIL lat1_done arready=%b rvalid=%b want 1/0",
               ar_ready[1], r_valid[1]);
    end
    do_read(1, 64'h10, lat);
    total++;
    if (lat !== 1 || r_data[1] !== 64'hAAAA) begin
      bad++;
      $display("FAIL lat1_b2b lat=%0d data=%h want 1/aaaa", lat, r_data[1]);
    end
    step();
  endtask

  task automatic test_lat15();
    int lat;
    r_ready = 1'b1;
    do_read(2, 64'h80, lat);
    total++;
    if (lat !== 15 || r_data[2] !== 64'h1122334455667788) begin
      bad++;
      $display("FAIL lat15 lat=%0d data=%h want 15/1122334455667788",
               lat, r_data[2]);
    end
    step();
    total++;
    if (ar_ready[2] !== 1'b1 || r_valid[2] !== 1'b0) begin
      bad++;
      $display("FAIL lat15_done arready=%b rvalid=%b want 1/0",
               ar_ready[2], r_valid[2]);
    end
  endtask

  initial begin
    rst       = 1'b1;
    ar_addr   = '0;
    ar_valid  = '0;
    ar_prot   = '0;
    r_ready   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_out_of_range();
    test_collision();
    test_reset_mid();
    test_lat1_back_to_back();
    test_lat15();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
